// File: rtl/nand_page_reader_if.sv
// nand_page_reader_if: host request, byte stream and flash bus signals of the page reader
interface nand_page_reader_if;
    logic        start;
    logic [15:0] col;
    logic [23:0] row;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        ndf_r_b_n;
    logic [7:0]  ndf_io_i;
    logic [7:0]  ndf_io_o;
    logic        ndf_io_oe;
    logic        ndf_ce_n;
    logic        ndf_cle;
    logic        ndf_ale;
    logic        ndf_we_n;
    logic        ndf_re_n;
    modport master (
        output start, col, row, rd_ready, ndf_r_b_n, ndf_io_i,
        input  busy, done, err, rd_data, rd_valid,
               ndf_io_o, ndf_io_oe, ndf_ce_n, ndf_cle, ndf_ale, ndf_we_n, ndf_re_n
    );
    modport slave (
        input  start, col, row, rd_ready, ndf_r_b_n, ndf_io_i,
        output busy, done, err, rd_data, rd_valid,
               ndf_io_o, ndf_io_oe, ndf_ce_n, ndf_cle, ndf_ale, ndf_we_n, ndf_re_n
    );
endinterface

// File: rtl/nand_page_reader.sv
// nand_page_reader: issues 00h/5 addr/30h, waits on R/B, then streams one page out over valid/ready
module nand_page_reader #(
    parameter int PAGE_BYTES     = 4096,
    parameter int TWB_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input logic               clk10,
    input logic               rst_n,
    nand_page_reader_if.slave bus
);
    localparam int CW = $clog2(PAGE_BYTES + 1);
    localparam int TL = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TW = TL < 20 ? 20 : TL;
    typedef enum logic [3:0] {IDLE, CMD1, ADDR, CMD2, TWB, WAIT_RDY, RE_LO, RE_HI, DONE} state_t;
    state_t        state, state_d;
    logic          ph, ph_d;
    logic [2:0]    idx, idx_d;
    logic [TW-1:0] tmo, tmo_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [15:0]   col_q, col_d;
    logic [23:0]   row_q, row_d;
    logic [1:0]    rb_s;
    logic          err_d, valid_d, wr;
    logic [7:0]    data_d, io_d;
    // Two-flop synchronizer for the asynchronous open-drain ready/busy line
    always_ff @(posedge clk10 or negedge rst_n)
        if (!rst_n) rb_s <= 2'b00;
        else        rb_s <= {rb_s[0], bus.ndf_r_b_n};
    // Next state, counters and the byte that the next bus write cycle drives
    always_comb begin
        state_d = state;
        ph_d    = ph;
        idx_d   = idx;
        tmo_d   = tmo;
        cnt_d   = cnt;
        col_d   = col_q;
        row_d   = row_q;
        err_d   = bus.err;
        valid_d = bus.rd_valid;
        data_d  = bus.rd_data;
        case (state)
            IDLE: if (bus.start) begin
                state_d = CMD1;
                col_d   = bus.col;
                row_d   = bus.row;
                err_d   = 1'b0;
            end
            CMD1: begin
                ph_d = ~ph;
                if (ph) begin
                    state_d = ADDR;
                    idx_d   = 3'd0;
                end
            end
            ADDR: begin
                ph_d = ~ph;
                if (ph) begin
                    idx_d   = idx + 3'd1;
                    state_d = idx == 3'd4 ? CMD2 : ADDR;
                end
            end
            CMD2: begin
                ph_d = ~ph;
                if (ph) begin
                    state_d = TWB;
                    tmo_d   = '0;
                end
            end
            TWB: begin
                tmo_d   = tmo == TW'(TWB_CYCLES - 1) ? '0 : tmo + 1'b1;
                state_d = tmo == TW'(TWB_CYCLES - 1) ? WAIT_RDY : TWB;
            end
            WAIT_RDY:
                if (rb_s[1]) begin
                    state_d = RE_LO;
                    cnt_d   = '0;
                end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else tmo_d = tmo + 1'b1;
            RE_LO: begin
                state_d = RE_HI;
                data_d  = bus.ndf_io_i;
                valid_d = 1'b1;
            end
            RE_HI: if (bus.rd_valid && bus.rd_ready) begin
                valid_d = 1'b0;
                cnt_d   = cnt + 1'b1;
                state_d = cnt_d == CW'(PAGE_BYTES) ? DONE : RE_LO;
            end
            default: state_d = IDLE;
        endcase
        wr   = state_d inside {CMD1, ADDR, CMD2};
        io_d = state_d == CMD2 ? 8'h30 :
               state_d != ADDR ? 8'h00 :
               idx_d == 3'd0   ? col_d[7:0] :
               idx_d == 3'd1   ? col_d[15:8] :
               idx_d == 3'd2   ? row_d[7:0] :
               idx_d == 3'd3   ? row_d[15:8] : row_d[23:16];
    end
    // State register; every output is registered from the next state so strobes are glitch-free
    always_ff @(posedge clk10 or negedge rst_n)
        if (!rst_n) begin
            state         <= IDLE;
            ph            <= 1'b0;
            idx           <= 3'd0;
            tmo           <= '0;
            cnt           <= '0;
            col_q         <= '0;
            row_q         <= '0;
            bus.ndf_ce_n  <= 1'b1;
            bus.ndf_cle   <= 1'b0;
            bus.ndf_ale   <= 1'b0;
            bus.ndf_we_n  <= 1'b1;
            bus.ndf_re_n  <= 1'b1;
            bus.ndf_io_oe <= 1'b0;
            bus.ndf_io_o  <= 8'h00;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            bus.rd_valid  <= 1'b0;
            bus.rd_data   <= 8'h00;
        end else begin
            state         <= state_d;
            ph            <= ph_d;
            idx           <= idx_d;
            tmo           <= tmo_d;
            cnt           <= cnt_d;
            col_q         <= col_d;
            row_q         <= row_d;
            bus.ndf_ce_n  <= state_d inside {IDLE, DONE};
            bus.ndf_cle   <= state_d inside {CMD1, CMD2};
            bus.ndf_ale   <= state_d == ADDR;
            bus.ndf_we_n  <= !(wr && !ph_d);
            bus.ndf_re_n  <= state_d != RE_LO;
            bus.ndf_io_oe <= wr;
            bus.ndf_io_o  <= io_d;
            bus.busy      <= state_d != IDLE;
            bus.done      <= state_d == DONE;
            bus.err       <= err_d;
            bus.rd_valid  <= valid_d;
            bus.rd_data   <= data_d;
        end
endmodule
